// File: rtl/single_ch_stream_tx.sv
// Transmit end of the single-channel windowed stream: buffers bursty source words in a
// small circular FIFO and replays them as one contiguous sel window followed by a frst pulse.
module single_ch_stream_tx #(
    parameter int             DW      = 27,
    parameter int             LEN_LOG = 2,
    parameter int             CW      = 13,
    parameter logic [CW-1:0]  WIN_LEN = 13'd4300
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          start,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          sel,
    output logic [DW-1:0] dout,
    output logic          frst,
    output logic          busy,
    output logic          underrun
);

    localparam int               DEPTH       = 1 << LEN_LOG;
    localparam int               PRIME_THR_I = (DEPTH < int'(WIN_LEN)) ? DEPTH : int'(WIN_LEN);
    localparam logic [LEN_LOG:0] PRIME_THR   = PRIME_THR_I[LEN_LOG:0];
    localparam logic [LEN_LOG:0] DEPTH_C     = DEPTH[LEN_LOG:0];
    localparam logic [CW-1:0]    LAST_IDX    = WIN_LEN - CW'(1);

    typedef enum logic [1:0] {IDLE, PRIME, SEND, END} state_t;

    state_t               state;
    state_t               next_state;
    logic [LEN_LOG:0]     count;
    logic [LEN_LOG-1:0]   wr_ptr;
    logic [LEN_LOG-1:0]   rd_ptr;
    logic [DW-1:0]        mem [DEPTH];
    logic [CW-1:0]        win_cnt;
    logic                 have_data;
    logic                 push;
    logic                 pop;

    logic                 sel_d;
    logic                 frst_d;
    logic [DW-1:0]        dout_d;
    logic                 underrun_d;
    logic [CW-1:0]        win_cnt_d;

    // Ready depends only on registered state/count; a full FIFO stays unready even while popping.
    assign have_data = (count != '0);
    assign s_ready   = (count < DEPTH_C) && (state != IDLE);
    assign busy      = (state != IDLE);
    assign push      = s_valid && s_ready && !abort;
    assign pop       = (state == SEND) && have_data && !abort;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = PRIME;
                PRIME:   if (count >= PRIME_THR) next_state = SEND;
                SEND:    if (win_cnt == LAST_IDX) next_state = END;
                END:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // An empty slot inside the window still advances the counter so the window length is fixed.
    always_comb begin
        sel_d      = (state == SEND) && !abort;
        frst_d     = abort || (state == END);
        dout_d     = pop ? mem[rd_ptr] : '0;
        underrun_d = underrun;
        win_cnt_d  = win_cnt;
        if (abort) begin
            win_cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        underrun_d = 1'b0;
                        win_cnt_d  = '0;
                    end
                end
                SEND: begin
                    win_cnt_d = win_cnt + CW'(1);
                    if (!have_data) underrun_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sel      <= 1'b0;
            dout     <= '0;
            frst     <= 1'b0;
            underrun <= 1'b0;
            win_cnt  <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            sel      <= sel_d;
            dout     <= dout_d;
            frst     <= frst_d;
            underrun <= underrun_d;
            win_cnt  <= win_cnt_d;
            if (abort) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + LEN_LOG'(1);
                if (pop)  rd_ptr <= rd_ptr + LEN_LOG'(1);
                case ({push, pop})
                    2'b10:   count <= count + (LEN_LOG+1)'(1);
                    2'b01:   count <= count - (LEN_LOG+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_single_ch_stream_tx.sv
// Bench for single_ch_stream_tx: directed window scenarios plus a random phase,
// compared every cycle against a queue-based reference of the window rules.
module tb_single_ch_stream_tx;

    localparam int DW        = 27;
    localparam int WIN_LEN   = 6;
    localparam int DEPTH     = 4;
    localparam int PRIME_THR = (DEPTH < WIN_LEN) ? DEPTH : WIN_LEN;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_SEND  = 2;
    localparam int M_CLOSE = 3;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          sel;
    logic [DW-1:0] dout;
    logic          frst;
    logic          busy;
    logic          underrun;

    single_ch_stream_tx #(
        .DW(DW), .LEN_LOG(2), .CW(13), .WIN_LEN(13'd6)
    ) dut (
        .CLK(CLK), .RST_X(RST_X), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .sel(sel), .dout(dout), .frst(frst), .busy(busy), .underrun(underrun)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: what the window should look like, tracked with a word queue and a slot count.
    int            m_mode;
    int            m_slot;
    logic          m_sel;
    logic          m_frst;
    logic          m_underrun;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_q [$];

    task automatic model_reset();
        m_q.delete();
        m_mode     = M_IDLE;
        m_slot     = 0;
        m_sel      = 1'b0;
        m_frst     = 1'b0;
        m_underrun = 1'b0;
        m_dout     = '0;
    endtask

    task automatic model_step();
        bit can_take;
        bit take;
        can_take = (m_mode != M_IDLE) && (m_q.size() < DEPTH);
        take     = s_valid && can_take && !abort;
        m_sel  = 1'b0;
        m_dout = '0;
        m_frst = 1'b0;
        if (abort) begin
            m_q.delete();
            m_mode = M_IDLE;
            m_slot = 0;
            m_frst = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start) begin
                        m_mode     = M_FILL;
                        m_slot     = 0;
                        m_underrun = 1'b0;
                    end
                end
                M_FILL: begin
                    if (m_q.size() >= PRIME_THR) m_mode = M_SEND;
                end
                M_SEND: begin
                    m_sel = 1'b1;
                    if (m_q.size() > 0) m_dout = m_q.pop_front();
                    else                m_underrun = 1'b1;
                    m_slot++;
                    if (m_slot == WIN_LEN) m_mode = M_CLOSE;
                end
                default: begin
                    m_frst = 1'b1;
                    m_mode = M_IDLE;
                end
            endcase
            if (take) m_q.push_back(s_data);
        end
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_output();
        check("sel",      DW'(sel),      DW'(m_sel));
        check("dout",     dout,          m_dout);
        check("frst",     DW'(frst),     DW'(m_frst));
        check("busy",     DW'(busy),     DW'(m_mode != M_IDLE));
        check("underrun", DW'(underrun), DW'(m_underrun));
        check("s_ready",  DW'(s_ready),  DW'((m_mode != M_IDLE) && (m_q.size() < DEPTH)));
    endtask

    task automatic apply_stimulus(input logic st, input logic ab, input logic vld);
        start   = st;
        abort   = ab;
        s_valid = vld;
        s_data  = DW'($urandom);
        model_step();
        @(posedge CLK);
        #1;
        check_output();
    endtask

    initial begin
        int seen;
        model_reset();
        @(posedge CLK);
        #1;
        check_output();
        RST_X = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0);

        // Full window from a continuously valid source; leftovers refill the FIFO.
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 19; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

        // Next window from leftovers only: four stored words then two empty slots.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) apply_stimulus(1'b0, 1'b0, 1'b0);

        // Abort while idle still pulses frst and empties the FIFO; then a stalled source.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  apply_stimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0, 1'b0);

        // Abort during the third visible sel cycle, with a push that must be dropped.
        apply_stimulus(1'b1, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (seen == 3) break;
            apply_stimulus(1'b0, 1'b0, 1'b1);
            if (m_sel) seen++;
        end
        apply_stimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)  apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

        // Start requests while sending or closing must not open a second window.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            apply_stimulus(m_mode == M_SEND || m_mode == M_CLOSE, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a window.
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (m_sel) break;
            apply_stimulus(1'b0, 1'b0, 1'b1);
        end
        RST_X = 1'b0;
        #1;
        model_reset();
        check_output();
        @(posedge CLK);
        #1;
        RST_X = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 19; i++) apply_stimulus(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            apply_stimulus(($urandom_range(5) == 0), ($urandom_range(49) == 0),
                           ($urandom_range(3) != 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
